nim_turn_engine: RTL and testbench

//  Parametrised Nim game controller: N rows of tokens, two players take turns.

---
 rtl/nim_turn_engine.sv | 159 +++++++++++++++
 tb/tb_nim_turn_engine.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/nim_turn_engine.sv
// Nim game controller: row-token counts, turn/lock tracking, game-end and winner detection.
// rowMask is a per-row thermometer decode of the registered counts, built by nim_row_mask lanes.

module nim_row_mask #(
  parameter int CNT_W      = 3,
  parameter int MAX_TOKENS = 7
) (
  input  logic [CNT_W-1:0]      cnt,
  output logic [MAX_TOKENS-1:0] mask
);
  always_comb begin
    mask = '0;
    for (int k = 0; k < MAX_TOKENS; k++) mask[k] = (32'(k) < 32'(cnt));
  end
endmodule

module nim_turn_engine #(
  parameter int                        NUM_ROWS    = 4,
  parameter int                        MAX_TOKENS  = 7,
  parameter int                        CNT_W       = $clog2(MAX_TOKENS + 1),
  parameter logic [NUM_ROWS*CNT_W-1:0] INIT_COUNTS = {3'd7, 3'd5, 3'd3, 3'd1},
  parameter int                        MAX_TAKE    = 0,
  parameter bit                        MISERE      = 1'b1,
  localparam int                       SEL_W       = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                           clk,
  input  logic                           newGame_n,
  input  logic                           start,
  input  logic [NUM_ROWS-1:0]            rowBtn,
  input  logic                           change,
  output logic                           playerTurn,
  output logic                           rowLocked,
  output logic [SEL_W-1:0]               selRow,
  output logic [NUM_ROWS*CNT_W-1:0]      rowCount,
  output logic [NUM_ROWS*MAX_TOKENS-1:0] rowMask,
  output logic                           gameOver,
  output logic                           winner,
  output logic                           illegal
);
  // A limit above MAX_TOKENS can never be reached, so it is treated as unlimited.
  localparam bit LIMITED = (MAX_TAKE > 0) && (MAX_TAKE <= MAX_TOKENS);

  function automatic bit init_ok();
    bit any = 1'b0;
    if (NUM_ROWS < 1 || NUM_ROWS > 8) return 1'b0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (32'(INIT_COUNTS[r*CNT_W +: CNT_W]) > 32'(MAX_TOKENS)) return 1'b0;
      if (INIT_COUNTS[r*CNT_W +: CNT_W] != '0) any = 1'b1;
    end
    return any;
  endfunction

  if (!init_ok()) begin : g_bad_init
    $error("nim_turn_engine: INIT_COUNTS/NUM_ROWS out of range or board empty");
  end

  typedef enum logic [1:0] {S_OPEN, S_LOCKED, S_OVER} state_t;

  state_t                             state;
  logic [NUM_ROWS-1:0][CNT_W-1:0]     cnt, nxt_cnt;
  logic [CNT_W-1:0]                   take_cnt, new_take, cur_cnt;
  logic [NUM_ROWS-1:0]                btn_q, row_edge;
  logic                               chg_q, chg_edge, multi, can_take;
  logic                               board_empty, turn_end, take_hit;
  logic [SEL_W-1:0]                   row_idx;

  assign rowCount = cnt;

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_lane
    nim_row_mask #(.CNT_W(CNT_W), .MAX_TOKENS(MAX_TOKENS)) u_mask (
      .cnt  (cnt[r]),
      .mask (rowMask[r*MAX_TOKENS +: MAX_TOKENS])
    );
  end

  always_comb begin
    row_edge = rowBtn & ~btn_q;
    chg_edge = change & ~chg_q;
    multi    = (row_edge & (row_edge - NUM_ROWS'(1))) != '0;
    row_idx  = '0;
    for (int i = 0; i < NUM_ROWS; i++) if (row_edge[i]) row_idx = SEL_W'(i);
    cur_cnt  = cnt[row_idx];
    can_take = (cur_cnt != '0) && ((state == S_OPEN) || (row_idx == selRow));
    nxt_cnt  = cnt;
    nxt_cnt[row_idx] = cur_cnt - CNT_W'(1);
    board_empty = (nxt_cnt == '0);
    new_take = (state == S_LOCKED) ? take_cnt + CNT_W'(1) : CNT_W'(1);
    take_hit = LIMITED && (32'(new_take) >= 32'(MAX_TAKE));
    turn_end = (nxt_cnt[row_idx] == '0) || take_hit;
  end

  always_ff @(posedge clk or negedge newGame_n) begin
    if (!newGame_n) begin
      cnt        <= INIT_COUNTS;
      state      <= S_OPEN;
      playerTurn <= 1'b1;
      rowLocked  <= 1'b0;
      selRow     <= '0;
      take_cnt   <= '0;
      gameOver   <= 1'b0;
      winner     <= 1'b0;
      illegal    <= 1'b0;
      btn_q      <= '1;
      chg_q      <= 1'b1;
    end else begin
      btn_q   <= rowBtn;
      chg_q   <= change;
      illegal <= 1'b0;
      if (start) begin
        cnt        <= INIT_COUNTS;
        state      <= S_OPEN;
        playerTurn <= 1'b1;
        rowLocked  <= 1'b0;
        selRow     <= '0;
        take_cnt   <= '0;
        gameOver   <= 1'b0;
        winner     <= 1'b0;
        btn_q      <= '1;
        chg_q      <= 1'b1;
      end else if (state != S_OVER) begin
        // A row edge wins over a simultaneous change edge.
        if (row_edge != '0) begin
          if (multi || !can_take) begin
            illegal <= 1'b1;
          end else begin
            cnt    <= nxt_cnt;
            selRow <= row_idx;
            if (board_empty) begin
              state      <= S_OVER;
              gameOver   <= 1'b1;
              winner     <= MISERE ? ~playerTurn : playerTurn;
              playerTurn <= ~playerTurn;
              rowLocked  <= 1'b0;
              take_cnt   <= '0;
            end else if (turn_end) begin
              state      <= S_OPEN;
              playerTurn <= ~playerTurn;
              rowLocked  <= 1'b0;
              take_cnt   <= '0;
            end else begin
              state     <= S_LOCKED;
              rowLocked <= 1'b1;
              take_cnt  <= new_take;
            end
          end
        end else if (chg_edge) begin
          if (state == S_OPEN) begin
            illegal <= 1'b1;
          end else begin
            state      <= S_OPEN;
            playerTurn <= ~playerTurn;
            rowLocked  <= 1'b0;
            take_cnt   <= '0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_nim_turn_engine.sv
// Directed bench for nim_turn_engine: default misere board, MAX_TAKE=2 board, and a small normal-rule board.
`timescale 1ns/1ps
module tb_nim_turn_engine;
  logic clk = 1'b0;
  logic ng  = 1'b0;
  always #5 clk = ~clk;

  // dut0: defaults (misere, unlimited take)
  logic [3:0]  btn0 = '0;
  logic        chg0 = 1'b0, st0 = 1'b0;
  logic        pt0, lk0, go0, win0, il0;
  logic [1:0]  sel0;
  logic [11:0] rc0;
  logic [27:0] rm0;
  // dut1: MAX_TAKE=2
  logic [3:0]  btn1 = '0;
  logic        chg1 = 1'b0, st1 = 1'b0;
  logic        pt1, lk1, go1, win1, il1;
  logic [1:0]  sel1;
  logic [11:0] rc1;
  logic [27:0] rm1;
  // dut2: two rows {2,1}, normal rule
  logic [1:0]  btn2 = '0;
  logic        chg2 = 1'b0, st2 = 1'b0;
  logic        pt2, lk2, go2, win2, il2;
  logic        sel2;
  logic [3:0]  rc2;
  logic [5:0]  rm2;

  int checks = 0;
  int errors = 0;

  nim_turn_engine dut0 (
    .clk(clk), .newGame_n(ng), .start(st0), .rowBtn(btn0), .change(chg0),
    .playerTurn(pt0), .rowLocked(lk0), .selRow(sel0), .rowCount(rc0), .rowMask(rm0),
    .gameOver(go0), .winner(win0), .illegal(il0));

  nim_turn_engine #(.MAX_TAKE(2)) dut1 (
    .clk(clk), .newGame_n(ng), .start(st1), .rowBtn(btn1), .change(chg1),
    .playerTurn(pt1), .rowLocked(lk1), .selRow(sel1), .rowCount(rc1), .rowMask(rm1),
    .gameOver(go1), .winner(win1), .illegal(il1));

  nim_turn_engine #(.NUM_ROWS(2), .MAX_TOKENS(3), .INIT_COUNTS(4'b10_01), .MISERE(1'b0)) dut2 (
    .clk(clk), .newGame_n(ng), .start(st2), .rowBtn(btn2), .change(chg2),
    .playerTurn(pt2), .rowLocked(lk2), .selRow(sel2), .rowCount(rc2), .rowMask(rm2),
    .gameOver(go2), .winner(win2), .illegal(il2));

  function automatic logic [11:0] pk(int c3, int c2, int c1, int c0);
    return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  function automatic logic [6:0] th(int c);
    return 7'((1 << c) - 1);
  endfunction

  function automatic logic [27:0] mk(int c3, int c2, int c1, int c0);
    return {th(c3), th(c2), th(c1), th(c0)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One press: drive high for one cycle, then release; returns with the effect registered.
  task automatic press(input int d, input logic [3:0] rows, input logic c);
    @(negedge clk);
    case (d)
      0: begin btn0 = rows; chg0 = c; end
      1: begin btn1 = rows; chg1 = c; end
      default: begin btn2 = rows[1:0]; chg2 = c; end
    endcase
    @(negedge clk);
    btn0 = '0; chg0 = 1'b0; btn1 = '0; chg1 = 1'b0; btn2 = '0; chg2 = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    ng = 1'b1;
    @(negedge clk);

    // reset state
    chk("rst_cnt",  rc0, pk(7,5,3,1));
    chk("rst_mask", rm0, {7'h7F, 7'h1F, 7'h07, 7'h01});
    chk("rst_turn", pt0, 1'b1);
    chk("rst_go",   go0, 1'b0);
    chk("rst_lock", lk0, 1'b0);
    chk("rst_ill",  il0, 1'b0);
    chk("rst_win",  win0, 1'b0);

    // left takes two from row2, then ends turn
    press(0, 4'b0100, 1'b0);
    chk("r2a_cnt", rc0, pk(7,4,3,1));
    chk("r2a_lk",  lk0, 1'b1);
    chk("r2a_sel", sel0, 2'd2);
    press(0, 4'b0100, 1'b0);
    chk("r2b_cnt",  rc0, pk(7,3,3,1));
    chk("r2b_mask", rm0, mk(7,3,3,1));
    press(0, 4'b0000, 1'b1);
    chk("chg_turn", pt0, 1'b0);
    chk("chg_lk",   lk0, 1'b0);
    chk("chg_ill",  il0, 1'b0);

    // change with no row chosen is rejected
    press(0, 4'b0000, 1'b1);
    chk("open_chg_ill",  il0, 1'b1);
    chk("open_chg_turn", pt0, 1'b0);

    // right locks row3, then tries row1
    press(0, 4'b1000, 1'b0);
    chk("r3_cnt", rc0, pk(6,3,3,1));
    chk("r3_sel", sel0, 2'd3);
    press(0, 4'b0010, 1'b0);
    chk("other_ill", il0, 1'b1);
    chk("other_cnt", rc0, pk(6,3,3,1));
    press(0, 4'b0000, 1'b1);
    chk("chg2_turn", pt0, 1'b1);

    // left empties row0: turn ends automatically
    press(0, 4'b0001, 1'b0);
    chk("auto_cnt",  rc0, pk(6,3,3,0));
    chk("auto_turn", pt0, 1'b0);
    chk("auto_lk",   lk0, 1'b0);
    press(0, 4'b0001, 1'b0);
    chk("empty_ill", il0, 1'b1);
    press(0, 4'b0110, 1'b0);
    chk("multi_ill", il0, 1'b1);
    chk("multi_cnt", rc0, pk(6,3,3,0));

    // row edge together with change: row wins, change dropped
    press(0, 4'b0010, 1'b1);
    chk("rowchg_cnt",  rc0, pk(6,3,2,0));
    chk("rowchg_lk",   lk0, 1'b1);
    chk("rowchg_turn", pt0, 1'b0);

    // play out: right finishes row1, left row2, right 5 of row3, left takes last
    repeat (2) press(0, 4'b0010, 1'b0);
    chk("p1_turn", pt0, 1'b1);
    repeat (3) press(0, 4'b0100, 1'b0);
    chk("p2_turn", pt0, 1'b0);
    repeat (5) press(0, 4'b1000, 1'b0);
    press(0, 4'b0000, 1'b1);
    chk("p3_cnt",  rc0, pk(1,0,0,0));
    chk("p3_turn", pt0, 1'b1);
    press(0, 4'b1000, 1'b0);
    chk("end_go",   go0, 1'b1);
    chk("end_win",  win0, 1'b0);
    chk("end_turn", pt0, 1'b0);
    chk("end_cnt",  rc0, 12'h000);
    chk("end_mask", rm0, 28'h0);
    press(0, 4'b1000, 1'b0);
    chk("over_ill", il0, 1'b0);
    press(0, 4'b0000, 1'b1);
    chk("over_chg_ill", il0, 1'b0);
    chk("over_go",      go0, 1'b1);

    // MAX_TAKE=2: third press goes to the new player
    press(1, 4'b1000, 1'b0);
    chk("mt1_cnt", rc1, pk(6,5,3,1));
    chk("mt1_lk",  lk1, 1'b1);
    press(1, 4'b1000, 1'b0);
    chk("mt2_cnt",  rc1, pk(5,5,3,1));
    chk("mt2_turn", pt1, 1'b0);
    chk("mt2_lk",   lk1, 1'b0);
    press(1, 4'b1000, 1'b0);
    chk("mt3_cnt",  rc1, pk(4,5,3,1));
    chk("mt3_turn", pt1, 1'b0);
    chk("mt3_sel",  sel1, 2'd3);

    // normal rule: left takes the last token and wins
    chk("n_rst_cnt",  rc2, 4'b1001);
    chk("n_rst_mask", rm2, 6'b011_001);
    press(2, 4'b0001, 1'b0);
    chk("n1_cnt",  rc2, 4'b1000);
    chk("n1_turn", pt2, 1'b0);
    press(2, 4'b0010, 1'b0);
    chk("n2_sel", sel2, 1'b1);
    press(2, 4'b0000, 1'b1);
    chk("n3_turn", pt2, 1'b1);
    press(2, 4'b0010, 1'b0);
    chk("n4_go",  go2, 1'b1);
    chk("n4_win", win2, 1'b1);
    chk("n4_cnt", rc2, 4'b0000);

    // start re-inits; a button held through start is not a press
    @(negedge clk); st0 = 1'b1; btn0 = 4'b1000;
    @(negedge clk); st0 = 1'b0;
    @(negedge clk);
    chk("st_cnt",  rc0, pk(7,5,3,1));
    chk("st_go",   go0, 1'b0);
    chk("st_turn", pt0, 1'b1);
    chk("st_win",  win0, 1'b0);
    btn0 = '0;
    @(negedge clk);
    chk("st_hold_cnt", rc0, pk(7,5,3,1));

    // async reset mid-turn discards everything
    press(0, 4'b0100, 1'b0);
    chk("pre_rst_lk", lk0, 1'b1);
    #3 ng = 1'b0;
    #1;
    chk("arst_cnt", rc0, pk(7,5,3,1));
    chk("arst_lk",  lk0, 1'b0);
    chk("arst_sel", sel0, 2'd0);
    @(negedge clk); ng = 1'b1;
    press(0, 4'b0001, 1'b0);
    chk("post_rst_cnt", rc0, pk(7,5,3,0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
